// File: rtl/tick_counter_pkg.sv
// Shared types and constants for the tick-driven mm:ss BCD counter.
package tick_counter_pkg;

   // Control FSM encoding; plain constants keep older tools happy.
   typedef logic [1:0] state_t;
   localparam state_t StIdle  = 2'd0;
   localparam state_t StRun   = 2'd1;
   localparam state_t StPause = 2'd2;

   // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // Default rollover limits for seconds and minutes.
   localparam int unsigned SEC_MAX_DEFAULT = 59;
   localparam int unsigned MIN_MAX_DEFAULT = 59;

   // Binary value of a two-digit BCD pair, used for limit compares.
   function automatic logic [6:0] bcd2_value(input logic [3:0] tens, input logic [3:0] units);
      return (7'(tens) * 7'd10) + 7'(units);
   endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD digit to active-low 7-segment decoder.
module seg7_decoder
   import tick_counter_pkg::*;
(
   input  logic [3:0] bcd_i,
   output logic [6:0] seg_o
);

   // Non-decimal codes blank the digit rather than show garbage.
   always_comb begin
      seg_o = SEG_BLANK;
      case (bcd_i)
         4'd0:    seg_o = SEG_0;
         4'd1:    seg_o = SEG_1;
         4'd2:    seg_o = SEG_2;
         4'd3:    seg_o = SEG_3;
         4'd4:    seg_o = SEG_4;
         4'd5:    seg_o = SEG_5;
         4'd6:    seg_o = SEG_6;
         4'd7:    seg_o = SEG_7;
         4'd8:    seg_o = SEG_8;
         4'd9:    seg_o = SEG_9;
         default: seg_o = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/tick_bcd_counter.sv
// mm:ss BCD stopwatch advanced by a single-cycle tick enable, with
// start/stop and clear buttons, four 7-segment outputs and a wrap pulse.
module tick_bcd_counter
   import tick_counter_pkg::*;
#(
   parameter int unsigned SEC_MAX = SEC_MAX_DEFAULT,
   parameter int unsigned MIN_MAX = MIN_MAX_DEFAULT
) (
   input  logic       clk,
   input  logic       _rst,
   input  logic       tick,
   input  logic       btn_start_stop,
   input  logic       btn_clear,
   output logic [6:0] hex0,
   output logic [6:0] hex1,
   output logic [6:0] hex2,
   output logic [6:0] hex3,
   output logic       led_running,
   output logic       wrap
);

   state_t     state_q, state_d;
   logic [3:0] sec_units_q, sec_units_d;
   logic [3:0] sec_tens_q, sec_tens_d;
   logic [3:0] min_units_q, min_units_d;
   logic [3:0] min_tens_q, min_tens_d;
   logic       wrap_q, wrap_d;
   logic       start_prev_q, clear_prev_q;

   logic       start_press, clear_press;
   logic       count_en;
   logic       sec_at_max, min_at_max;

   // Rising-edge detect; history resets high so a held button does not fire.
   assign start_press = btn_start_stop & ~start_prev_q;
   assign clear_press = btn_clear & ~clear_prev_q;

   // Clear overrides any tick in the same cycle.
   assign count_en = tick & (state_q == StRun) & ~clear_press;

   assign sec_at_max = (bcd2_value(sec_tens_q, sec_units_q) == 7'(SEC_MAX));
   assign min_at_max = (bcd2_value(min_tens_q, min_units_q) == 7'(MIN_MAX));

   // Run/pause control; clear wins over start in the same cycle.
   always_comb begin
      state_d = state_q;
      if (clear_press) begin
         state_d = StIdle;
      end else if (start_press) begin
         case (state_q)
            StIdle:  state_d = StRun;
            StRun:   state_d = StPause;
            StPause: state_d = StRun;
            default: state_d = StIdle;
         endcase
      end else if (state_q != StIdle && state_q != StRun && state_q != StPause) begin
         state_d = StIdle;
      end
   end

   // BCD digit chain with seconds and minutes rollover and wrap flag.
   always_comb begin
      sec_units_d = sec_units_q;
      sec_tens_d  = sec_tens_q;
      min_units_d = min_units_q;
      min_tens_d  = min_tens_q;
      wrap_d      = 1'b0;
      if (clear_press) begin
         sec_units_d = 4'd0;
         sec_tens_d  = 4'd0;
         min_units_d = 4'd0;
         min_tens_d  = 4'd0;
      end else if (count_en) begin
         if (sec_at_max) begin
            sec_units_d = 4'd0;
            sec_tens_d  = 4'd0;
            if (min_at_max) begin
               min_units_d = 4'd0;
               min_tens_d  = 4'd0;
               wrap_d      = 1'b1;
            end else if (min_units_q == 4'd9) begin
               min_units_d = 4'd0;
               min_tens_d  = min_tens_q + 4'd1;
            end else begin
               min_units_d = min_units_q + 4'd1;
            end
         end else if (sec_units_q == 4'd9) begin
            sec_units_d = 4'd0;
            sec_tens_d  = sec_tens_q + 4'd1;
         end else begin
            sec_units_d = sec_units_q + 4'd1;
         end
      end
   end

   // All state registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!_rst) begin
         state_q      <= StIdle;
         sec_units_q  <= 4'd0;
         sec_tens_q   <= 4'd0;
         min_units_q  <= 4'd0;
         min_tens_q   <= 4'd0;
         wrap_q       <= 1'b0;
         start_prev_q <= 1'b1;
         clear_prev_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         sec_units_q  <= sec_units_d;
         sec_tens_q   <= sec_tens_d;
         min_units_q  <= min_units_d;
         min_tens_q   <= min_tens_d;
         wrap_q       <= wrap_d;
         start_prev_q <= btn_start_stop;
         clear_prev_q <= btn_clear;
      end
   end

   assign led_running = (state_q == StRun);
   assign wrap        = wrap_q;

   seg7_decoder u_dec_sec_units (
      .bcd_i (sec_units_q),
      .seg_o (hex0)
   );

   seg7_decoder u_dec_sec_tens (
      .bcd_i (sec_tens_q),
      .seg_o (hex1)
   );

   seg7_decoder u_dec_min_units (
      .bcd_i (min_units_q),
      .seg_o (hex2)
   );

   seg7_decoder u_dec_min_tens (
      .bcd_i (min_tens_q),
      .seg_o (hex3)
   );

endmodule

// File: tb/tb_tick_bcd_counter.sv
// Scoreboard bench for tick_bcd_counter: a binary-time reference model
// pushes the expected display each cycle, popped and compared after the edge.
module tb_tick_bcd_counter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tick = 1'b0;
   logic       btn_ss = 1'b0;
   logic       btn_clr = 1'b0;
   logic [6:0] hex0, hex1, hex2, hex3;
   logic       led_running, wrap;

   int checks = 0;
   int failures = 0;

   typedef struct packed {
      logic [6:0] h0;
      logic [6:0] h1;
      logic [6:0] h2;
      logic [6:0] h3;
      logic       led;
      logic       wrp;
   } exp_t;

   exp_t sb_q[$];

   // Reference model state: total seconds 0..3599, 0=idle 1=run 2=pause.
   int   m_total = 0;
   int   m_state = 0;
   logic m_wrap = 1'b0;
   logic m_sp = 1'b1;
   logic m_cp = 1'b1;

   logic [6:0] seg_tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

   tick_bcd_counter dut (
      .clk            (clk),
      ._rst           (rst_n),
      .tick           (tick),
      .btn_start_stop (btn_ss),
      .btn_clear      (btn_clr),
      .hex0           (hex0),
      .hex1           (hex1),
      .hex2           (hex2),
      .hex3           (hex3),
      .led_running    (led_running),
      .wrap           (wrap)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int unsigned act, input int unsigned exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic exp_t model_view();
      exp_t e;
      int   s, m;
      s     = m_total % 60;
      m     = m_total / 60;
      e.h0  = seg_tbl[s % 10];
      e.h1  = seg_tbl[s / 10];
      e.h2  = seg_tbl[m % 10];
      e.h3  = seg_tbl[m / 10];
      e.led = (m_state == 1);
      e.wrp = m_wrap;
      return e;
   endfunction

   // One clock cycle: drive inputs, advance model, push, then compare after the edge.
   task automatic step(input logic t, input logic ss, input logic clr, input logic rst);
      logic sp, cp;
      exp_t e, got;
      tick    = t;
      btn_ss  = ss;
      btn_clr = clr;
      rst_n   = rst;
      if (!rst) begin
         m_state = 0;
         m_total = 0;
         m_wrap  = 1'b0;
         m_sp    = 1'b1;
         m_cp    = 1'b1;
      end else begin
         sp     = ss & ~m_sp;
         cp     = clr & ~m_cp;
         m_wrap = 1'b0;
         if (cp) begin
            m_state = 0;
            m_total = 0;
         end else begin
            if (m_state == 1 && t) begin
               m_total++;
               if (m_total == 3600) begin
                  m_total = 0;
                  m_wrap  = 1'b1;
               end
            end
            if (sp) m_state = (m_state == 1) ? 2 : 1;
         end
         m_sp = ss;
         m_cp = clr;
      end
      sb_q.push_back(model_view());
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      got = '{h0: hex0, h1: hex1, h2: hex2, h3: hex3, led: led_running, wrp: wrap};
      check_eq("hex0", got.h0, e.h0);
      check_eq("hex1", got.h1, e.h1);
      check_eq("hex2", got.h2, e.h2);
      check_eq("hex3", got.h3, e.h3);
      check_eq("led_running", got.led, e.led);
      check_eq("wrap", got.wrp, e.wrp);
   endtask

   task automatic press_start();
      step(1'b0, 1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      int wrap_cycles;
      @(posedge clk);
      #1;
      repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
      check_eq("reset_hex0", hex0, 7'b1000000);
      check_eq("reset_hex3", hex3, 7'b1000000);
      check_eq("reset_led", led_running, 1'b0);
      check_eq("reset_wrap", wrap, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b1);  // idle tick ignored
      check_eq("idle_tick_hex0", hex0, 7'b1000000);

      // Start, then five ticks spaced ten cycles apart.
      press_start();
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b0, 1'b0, 1'b1);
         repeat (9) step(1'b0, 1'b0, 1'b0, 1'b1);
      end
      check_eq("five_hex0", hex0, 7'b0010010);
      check_eq("five_hex1", hex1, 7'b1000000);
      check_eq("five_hex2", hex2, 7'b1000000);
      check_eq("five_led", led_running, 1'b1);

      // Up to 00:59, then across the minute boundary.
      repeat (54) step(1'b1, 1'b0, 1'b0, 1'b1);
      check_eq("s59_hex0", hex0, 7'b0010000);
      check_eq("s59_hex1", hex1, 7'b0010010);
      step(1'b1, 1'b0, 1'b0, 1'b1);
      check_eq("m1_hex0", hex0, 7'b1000000);
      check_eq("m1_hex1", hex1, 7'b1000000);
      check_eq("m1_hex2", hex2, 7'b1111001);

      // Clear, restart, preload to 59:59 and wrap.
      step(1'b0, 1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      check_eq("clr_led", led_running, 1'b0);
      press_start();
      repeat (3599) step(1'b1, 1'b0, 1'b0, 1'b1);
      check_eq("pre_hex3", hex3, 7'b0010010);
      check_eq("pre_hex0", hex0, 7'b0010000);
      step(1'b1, 1'b0, 1'b0, 1'b1);
      check_eq("wrap_hi", wrap, 1'b1);
      check_eq("wrap_hex3", hex3, 7'b1000000);
      wrap_cycles = 0;
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b0, 1'b0, 1'b1);
         if (wrap) wrap_cycles++;
      end
      check_eq("wrap_extra_cycles", wrap_cycles, 0);
      check_eq("wrap_still_run", led_running, 1'b1);

      // 00:07, start together with tick: counted, then paused.
      repeat (7) step(1'b1, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      repeat (3) step(1'b1, 1'b0, 1'b0, 1'b1);
      check_eq("pause_hex0", hex0, 7'b0000000);
      check_eq("pause_led", led_running, 1'b0);

      // Resume: pause+tick+start ignores the tick, then run to 12:34.
      step(1'b1, 1'b1, 1'b0, 1'b1);
      check_eq("resume_hex0", hex0, 7'b0000000);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      repeat (746) step(1'b1, 1'b0, 1'b0, 1'b1);
      check_eq("t1234_hex2", hex2, 7'b0100100);
      check_eq("t1234_hex0", hex0, 7'b0011001);
      press_start();
      step(1'b1, 1'b1, 1'b1, 1'b1);  // clear beats start and tick
      check_eq("clrpri_led", led_running, 1'b0);
      check_eq("clrpri_hex2", hex2, 7'b1000000);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b1);
      check_eq("clrpri_tick_ign", hex0, 7'b1000000);

      // Start held through reset must not register a press.
      press_start();
      repeat (3) step(1'b1, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      check_eq("midrst_hex0", hex0, 7'b1000000);
      repeat (3) step(1'b1, 1'b1, 1'b0, 1'b1);
      check_eq("held_led", led_running, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b0, 1'b1);
      check_eq("repress_led", led_running, 1'b1);
      repeat (2) step(1'b1, 1'b1, 1'b0, 1'b1);
      check_eq("repress_hex0", hex0, 7'b0100100);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
